// File: rtl/ntt_coef_ram.sv
//==============================================================================
// Module      : ntt_coef_ram
// Description : Eight-lane coefficient RAM answering the NTT word port, plus a
//               host streaming port that scatters/gathers a natural-order
//               polynomial to/from the interleaved bit-reversed word layout.
//               Optional: `define COEF_REDUCE_EN to reduce loaded coefs >= Q.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ntt_coef_ram #(
    parameter int AW    = 8,
    parameter int CW    = 12,
    parameter int LANES = 8,
    parameter int Q     = 3329
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         r_data_addr,
    output logic [LANES*CW-1:0]   r_data,
    input  logic                  w_data_en,
    input  logic [AW-1:0]         w_data_addr,
    input  logic [LANES*CW-1:0]   w_data,
    input  logic                  ntt_busy,
    input  logic                  host_load,
    input  logic                  host_unload,
    input  logic [AW-1:0]         host_base,
    input  logic                  host_in_valid,
    output logic                  host_in_ready,
    input  logic [CW-1:0]         host_in_coef,
    output logic                  host_out_valid,
    input  logic                  host_out_ready,
    output logic [CW-1:0]         host_out_coef,
    output logic                  host_busy,
    output logic                  host_done
);

    localparam logic [CW-1:0] c_Q = CW'(Q);
`ifdef COEF_REDUCE_EN
    localparam bit c_REDUCE = 1'b1;
`else
    localparam bit c_REDUCE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_UNLOAD = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CW-1:0] r_mem [LANES][2**AW];
    logic [AW-1:0] r_base;
    logic [8:0]    r_idx;       // coefficient index: load beats, or unload reads issued
    logic [7:0]    r_out_cnt;
    logic          r_rd_vld;
    logic [CW-1:0] r_rd_coef;
    logic [CW-1:0] r_fifo [2];
    logic          r_wptr, r_rptr;
    logic [1:0]    r_cnt;

    logic [AW-1:0] w_map_word;
    logic [2:0]    w_map_lane;
    logic [CW-1:0] w_store_coef;
    logic          w_host_wr, w_issue, w_pop, w_start;
    logic [2:0]    w_occ;

    // lane = 4*i[6] + 2*i[7] + i[0]; word = base + bitrev5(i[5:1])
    assign w_map_lane = {r_idx[6], r_idx[7], r_idx[0]};
    assign w_map_word = r_base + AW'({r_idx[1], r_idx[2], r_idx[3], r_idx[4], r_idx[5]});

    assign w_store_coef = (c_REDUCE && (host_in_coef >= c_Q)) ? (host_in_coef - c_Q)
                                                              : host_in_coef;

    assign w_host_wr      = host_in_valid && host_in_ready;
    assign host_out_valid = (r_cnt != 2'd0);
    assign host_out_coef  = r_fifo[r_rptr];
    assign w_pop          = host_out_valid && host_out_ready;
    // Occupancy the FIFO will see once the in-flight read lands and this pop retires
    assign w_occ          = 3'(r_cnt) + 3'(r_rd_vld) - 3'(w_pop);
    assign w_issue        = (r_state == S_UNLOAD) && !r_idx[8] && (w_occ < 3'd2);
    assign w_start        = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        host_in_ready = 1'b0;
        host_busy     = 1'b1;
        host_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                host_busy = 1'b0;
                if (host_load && !ntt_busy)
                    w_state_nxt = S_LOAD;
                else if (host_unload && !ntt_busy)
                    w_state_nxt = S_UNLOAD;
            end
            S_LOAD: begin
                host_in_ready = !w_data_en;
                if (host_in_valid && !w_data_en && (r_idx[7:0] == 8'hFF))
                    w_state_nxt = S_DONE;
            end
            S_UNLOAD: begin
                if (w_pop && (r_out_cnt == 8'hFF))
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                host_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Storage is never reset so a reset mid-load keeps what was written
    always_ff @(posedge clk) begin
        if (w_data_en) begin
            for (int j = 0; j < LANES; j++)
                r_mem[j][w_data_addr] <= w_data[j*CW +: CW];
        end
        if (w_host_wr)
            r_mem[w_map_lane][w_map_word] <= w_store_coef;
        r_rd_coef <= r_mem[w_map_lane][w_map_word];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else begin
            for (int j = 0; j < LANES; j++)
                r_data[j*CW +: CW] <= r_mem[j][r_data_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base    <= '0;
            r_idx     <= '0;
            r_out_cnt <= '0;
            r_rd_vld  <= 1'b0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_cnt     <= '0;
        end else if (w_start) begin
            r_base    <= host_base;
            r_idx     <= '0;
            r_out_cnt <= '0;
            r_rd_vld  <= 1'b0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_host_wr || w_issue)
                r_idx <= r_idx + 9'd1;
            r_rd_vld <= w_issue;
            if (r_rd_vld) begin
                r_fifo[r_wptr] <= r_rd_coef;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr    <= ~r_rptr;
                r_out_cnt <= r_out_cnt + 8'd1;
            end
            r_cnt <= r_cnt + 2'(r_rd_vld) - 2'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ntt_coef_ram.sv
//==============================================================================
// Module      : tb_ntt_coef_ram
// Description : Self-checking bench for ntt_coef_ram (scoreboard queues).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ntt_coef_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  r_data_addr;
    logic [95:0] r_data;
    logic        w_data_en;
    logic [7:0]  w_data_addr;
    logic [95:0] w_data;
    logic        ntt_busy;
    logic        host_load;
    logic        host_unload;
    logic [7:0]  host_base;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [11:0] host_in_coef;
    logic        host_out_valid;
    logic        host_out_ready;
    logic [11:0] host_out_coef;
    logic        host_busy;
    logic        host_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] vals [256];
    logic [95:0] exp_word_q [$];
    logic [11:0] exp_coef_q [$];

    always #5 clk = ~clk;

    ntt_coef_ram dut (
        .clk(clk), .rst(rst_n),
        .r_data_addr(r_data_addr), .r_data(r_data),
        .w_data_en(w_data_en), .w_data_addr(w_data_addr), .w_data(w_data),
        .ntt_busy(ntt_busy), .host_load(host_load), .host_unload(host_unload),
        .host_base(host_base), .host_in_valid(host_in_valid),
        .host_in_ready(host_in_ready), .host_in_coef(host_in_coef),
        .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
        .host_out_coef(host_out_coef), .host_busy(host_busy), .host_done(host_done)
    );

    function automatic logic [95:0] w8(input int a7, a6, a5, a4, a3, a2, a1, a0);
        return {12'(a7), 12'(a6), 12'(a5), 12'(a4), 12'(a3), 12'(a2), 12'(a1), 12'(a0)};
    endfunction

    task automatic ntt_read(input logic [7:0] a, input logic [95:0] e, input string nm);
        logic [95:0] x;
        @(negedge clk);
        r_data_addr = a;
        exp_word_q.push_back(e);
        @(negedge clk);
        x = exp_word_q.pop_front();
        n_cmp++;
        if (r_data !== x) begin
            n_bad++;
            $display("FAIL %s: r_data=%h expected=%h", nm, r_data, x);
        end
    endtask

    task automatic run_load(input logic [7:0] base, input int stop_at, input bit poke,
                            output int accepted);
        int i, cyc;
        bit poked;
        i = 0; cyc = 0; poked = 0;
        @(negedge clk);
        host_load = 1'b1; host_base = base;
        @(negedge clk);
        host_load = 1'b0;
        while (i < stop_at && cyc < 2000) begin
            host_in_valid = 1'b1;
            host_in_coef  = vals[i];
            if (poke && i == 50 && !poked) begin
                w_data_en = 1'b1; w_data_addr = 8'd200;
                w_data = 96'hABC_123_456_789_FED_0A1_B2C_3D4;
                poked = 1;
                #1;
                n_cmp++;
                if (host_in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ntt_prio_ready: host_in_ready=%b expected=0", host_in_ready);
                end
            end else begin
                w_data_en = 1'b0;
                #1;
                if (host_in_ready) i++;
            end
            @(negedge clk);
            cyc++;
        end
        host_in_valid = 1'b0;
        w_data_en = 1'b0;
        accepted = i;
        n_cmp++;
        if (i != stop_at) begin
            n_bad++;
            $display("FAIL load_timeout: accepted=%0d expected=%0d", i, stop_at);
        end
    endtask

    task automatic check_done(input string nm);
        n_cmp++;
        if (host_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done: host_done=%b expected=1", nm, host_done);
        end
        @(negedge clk);
        n_cmp++;
        if (host_done !== 1'b0 || host_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: done=%b busy=%b expected=0/0", nm, host_done, host_busy);
        end
    endtask

    task automatic run_unload(input logic [7:0] base, input bit rnd, input string nm);
        int beats, cyc;
        bit held;
        logic [11:0] held_coef, x;
        beats = 0; cyc = 0; held = 0; held_coef = '0;
        for (int k = 0; k < 256; k++) exp_coef_q.push_back(vals[k]);
        @(negedge clk);
        host_unload = 1'b1; host_base = base;
        @(negedge clk);
        host_unload = 1'b0;
        while (beats < 256 && cyc < 3000) begin
            host_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held) begin
                n_cmp++;
                if (host_out_valid !== 1'b1 || host_out_coef !== held_coef) begin
                    n_bad++;
                    $display("FAIL %s_hold: valid=%b coef=%0d expected=1/%0d",
                             nm, host_out_valid, host_out_coef, held_coef);
                end
            end
            if (host_out_valid && host_out_ready) begin
                x = exp_coef_q.pop_front();
                n_cmp++;
                if (host_out_coef !== x) begin
                    n_bad++;
                    $display("FAIL %s_beat%0d: coef=%0d expected=%0d", nm, beats, host_out_coef, x);
                end
                beats++;
                held = 0;
            end else if (host_out_valid) begin
                held = 1;
                held_coef = host_out_coef;
            end else begin
                held = 0;
            end
            @(negedge clk);
            cyc++;
        end
        host_out_ready = 1'b0;
        exp_coef_q.delete();
        n_cmp++;
        if (beats != 256) begin
            n_bad++;
            $display("FAIL %s_beats: beats=%0d expected=256", nm, beats);
        end
        n_cmp++;
        if (host_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_extra: host_out_valid=%b expected=0", nm, host_out_valid);
        end
        check_done(nm);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r_data_addr = '0; w_data_en = 0; w_data_addr = '0; w_data = '0;
        ntt_busy = 0; host_load = 0; host_unload = 0; host_base = '0;
        host_in_valid = 0; host_in_coef = '0; host_out_ready = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (r_data !== 96'd0) begin n_bad++; $display("FAIL rst_r_data: %h expected 0", r_data); end
        n_cmp++;
        if ({host_in_ready, host_out_valid, host_busy, host_done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_flags: rdy/vld/busy/done=%b expected=0000",
                     {host_in_ready, host_out_valid, host_busy, host_done});
        end
        n_cmp++;
        if (host_out_coef !== 12'd0) begin n_bad++; $display("FAIL rst_coef: %0d expected 0", host_out_coef); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_read();
        int acc;
        for (int k = 0; k < 256; k++) vals[k] = 12'(k);
        run_load(8'd0, 256, 1'b0, acc);
        check_done("load0");
        ntt_read(8'd0,  w8(193, 192, 65, 64, 129, 128, 1, 0),    "rd_addr0");
        ntt_read(8'd1,  w8(225, 224, 97, 96, 161, 160, 33, 32),  "rd_addr1");
        ntt_read(8'd31, w8(255, 254, 127, 126, 191, 190, 63, 62), "rd_addr31");
    endtask

    task automatic test_unload_stall();
        run_unload(8'd0, 1'b1, "unload_stall");
    endtask

    task automatic test_reset_mid();
        int acc;
        for (int k = 0; k < 256; k++) vals[k] = 12'(1000 + k);
        run_load(8'd0, 100, 1'b0, acc);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({host_in_ready, host_out_valid, host_busy, host_done} !== 4'b0000 ||
            r_data !== 96'd0 || host_out_coef !== 12'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: flags=%b r_data=%h coef=%0d expected all 0",
                     {host_in_ready, host_out_valid, host_busy, host_done}, r_data, host_out_coef);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ntt_read(8'd0,  w8(193, 192, 1065, 1064, 129, 128, 1001, 1000), "midrst_word0");
        ntt_read(8'd31, w8(255, 254, 127, 126, 191, 190, 1063, 1062),   "midrst_word31");
    endtask

    task automatic test_wrap();
        int acc;
        for (int k = 0; k < 256; k++) vals[k] = 12'(256 + k);
        run_load(8'd250, 256, 1'b0, acc);
        check_done("load250");
        ntt_read(8'd250, w8(449, 448, 321, 320, 385, 384, 257, 256), "wrap_word250");
        ntt_read(8'd25,  w8(511, 510, 383, 382, 447, 446, 319, 318), "wrap_word25");
        run_unload(8'd250, 1'b0, "unload250");
    endtask

    task automatic test_ntt_write_during_load();
        int acc;
        for (int k = 0; k < 256; k++) vals[k] = 12'((k * 13 + 7) % 4096);
        run_load(8'd100, 256, 1'b1, acc);
        check_done("loadpoke");
        ntt_read(8'd200, 96'hABC_123_456_789_FED_0A1_B2C_3D4, "poke_word");
        ntt_read(8'd100, w8(vals[193], vals[192], vals[65], vals[64],
                            vals[129], vals[128], vals[1], vals[0]), "poke_load_word");
    endtask

    task automatic test_busy_block();
        @(negedge clk);
        ntt_busy = 1'b1; host_load = 1'b1; host_unload = 1'b1;
        @(negedge clk);
        host_load = 1'b0; host_unload = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (host_busy !== 1'b0 || host_in_ready !== 1'b0 || host_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_block: busy=%b rdy=%b vld=%b expected=0/0/0",
                     host_busy, host_in_ready, host_out_valid);
        end
        ntt_busy = 1'b0;
    endtask

    task automatic test_reduce();
        int acc;
        int s0, s1, s2;
`ifdef COEF_REDUCE_EN
        s0 = 0; s1 = 766; s2 = 3328;
`else
        s0 = 3329; s1 = 4095; s2 = 3328;
`endif
        for (int k = 0; k < 256; k++) vals[k] = 12'(k);
        vals[0] = 12'd3329; vals[1] = 12'd4095; vals[2] = 12'd3328;
        run_load(8'd0, 256, 1'b0, acc);
        check_done("loadred");
        ntt_read(8'd0,  w8(193, 192, 65, 64, 129, 128, s1, s0), "reduce_word0");
        ntt_read(8'd16, w8(195, 194, 67, 66, 131, 130, 3, s2),  "reduce_word16");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_read();
        test_unload_stall();
        test_reset_mid();
        test_wrap();
        test_ntt_write_during_load();
        test_busy_block();
        test_reduce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
